// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 load/store unit.
//   LOAD_* / STORE_*  : RV32I funct3 encodings for memory instructions
//   lsu_state_t       : LSU sequencing states
package msrv32_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/msrv32_lsu_align.sv
// Combinational lane logic for the load/store unit.
//   Issue side  : funct3_i, addr_lo_i, store_data_i, is_load_i, is_store_i
//                 -> wdata_o (lane-replicated), wstrb_o, misaligned_o, illegal_o
//   Return side : ld_funct3_i, ld_addr_lo_i, rdata_i -> ld_data_o (extended)
// misaligned_o is only raised for a legal funct3; illegal encodings and
// load+store together report illegal_o instead.
module msrv32_lsu_align
    import msrv32_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] lane;

    always_comb begin
        wdata_o      = '0;
        wstrb_o      = '0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        if (is_load_i && is_store_i) begin
            illegal_o = 1'b1;
        end else if (is_store_i) begin
            case (funct3_i)
                STORE_SB: begin
                    wdata_o = {4{store_data_i[7:0]}};
                    wstrb_o = 4'b0001 << addr_lo_i;
                end
                STORE_SH: begin
                    wdata_o      = {2{store_data_i[15:0]}};
                    wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    misaligned_o = addr_lo_i[0];
                end
                STORE_SW: begin
                    wdata_o      = store_data_i;
                    wstrb_o      = 4'b1111;
                    misaligned_o = |addr_lo_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end else if (is_load_i) begin
            case (funct3_i)
                LOAD_LB, LOAD_LBU: misaligned_o = 1'b0;
                LOAD_LH, LOAD_LHU: misaligned_o = addr_lo_i[0];
                LOAD_LW:           misaligned_o = |addr_lo_i;
                default:           illegal_o    = 1'b1;
            endcase
        end
    end

    always_comb begin
        lane = rdata_i >> {ld_addr_lo_i, 3'b000};
        case (ld_funct3_i)
            LOAD_LB:  ld_data_o = {{24{lane[7]}}, lane[7:0]};
            LOAD_LH:  ld_data_o = {{16{lane[15]}}, lane[15:0]};
            LOAD_LBU: ld_data_o = {24'b0, lane[7:0]};
            LOAD_LHU: ld_data_o = {16'b0, lane[15:0]};
            default:  ld_data_o = lane;
        endcase
    end

endmodule

// File: rtl/msrv32_lsu.sv
// msrv32 load/store unit: one data-memory transaction per accepted
// instruction over a req/ack bus, one completion pulse per instruction.
//   Issue    : valid_in/ready_out, load_in, store_in, funct3_in, addr_in,
//              store_data_in, rd_addr_in
//   Bus      : dmem_req/we/addr/wdata/wstrb_out, dmem_ack/err/rdata_in
//   Complete : done_out, wb_we_out, wb_rd_out, wb_data_out,
//              misaligned_out, access_fault_out, fault_addr_out
//
// state | meaning
// IDLE  | ready for an instruction, bus idle
// BUSY  | request on the bus, waiting for ack or timeout
// DONE  | one-cycle completion pulse with outcome flags
module msrv32_lsu
    import msrv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        valid_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_addr_in,
    output logic        ready_out,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wstrb_out,
    input  logic        dmem_ack_in,
    input  logic        dmem_err_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        done_out,
    output logic        wb_we_out,
    output logic [4:0]  wb_rd_out,
    output logic [31:0] wb_data_out,
    output logic        misaligned_out,
    output logic        access_fault_out,
    output logic [31:0] fault_addr_out
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;

    logic        req_q, we_q, load_q;
    logic [31:0] dmem_addr_q, wdata_q, addr_q, wb_data_q, fault_addr_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [15:0] cnt_q;
    logic        ld_ok_q, mis_q, af_q;

    logic [31:0] al_wdata, ld_data;
    logic [3:0]  al_wstrb;
    logic        al_mis, al_illegal;
    logic        issue, timeout;

    msrv32_lsu_align u_align (
        .funct3_i     (funct3_in),
        .addr_lo_i    (addr_in[1:0]),
        .store_data_i (store_data_in),
        .is_load_i    (load_in),
        .is_store_i   (store_in),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .misaligned_o (al_mis),
        .illegal_o    (al_illegal),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_q[1:0]),
        .rdata_i      (dmem_rdata_in),
        .ld_data_o    (ld_data)
    );

    // valid_in with neither class bit set is a no-op and leaves IDLE untouched
    assign issue   = (state_q == IDLE) && valid_in && (load_in || store_in);
    assign timeout = (cnt_q == CNT_LAST) && !dmem_ack_in;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) state_q <= IDLE;
        else                         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (issue) state_d = (al_illegal || al_mis) ? DONE : BUSY;
            BUSY: if (dmem_ack_in || timeout) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out        = (state_q == IDLE);
        done_out         = (state_q == DONE);
        wb_we_out        = (state_q == DONE) && ld_ok_q;
        misaligned_out   = (state_q == DONE) && mis_q;
        access_fault_out = (state_q == DONE) && af_q;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            load_q       <= 1'b0;
            dmem_addr_q  <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            ld_ok_q      <= 1'b0;
            mis_q        <= 1'b0;
            af_q         <= 1'b0;
            wb_data_q    <= '0;
            fault_addr_q <= '0;
        end else if (issue) begin
            rd_q     <= rd_addr_in;
            addr_q   <= addr_in;
            funct3_q <= funct3_in;
            load_q   <= load_in;
            cnt_q    <= '0;
            ld_ok_q  <= 1'b0;
            mis_q    <= al_mis;
            af_q     <= al_illegal;
            if (al_illegal || al_mis) begin
                fault_addr_q <= addr_in;
            end else begin
                req_q       <= 1'b1;
                we_q        <= store_in;
                dmem_addr_q <= {addr_in[31:2], 2'b00};
                wdata_q     <= al_wdata;
                wstrb_q     <= al_wstrb;
            end
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 16'd1;
            if (dmem_ack_in) begin
                req_q <= 1'b0;
                if (dmem_err_in) begin
                    af_q         <= 1'b1;
                    fault_addr_q <= addr_q;
                end else if (load_q) begin
                    ld_ok_q   <= 1'b1;
                    wb_data_q <= ld_data;
                end
            end else if (timeout) begin
                req_q        <= 1'b0;
                af_q         <= 1'b1;
                fault_addr_q <= addr_q;
            end
        end
    end

    assign dmem_req_out   = req_q;
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = dmem_addr_q;
    assign dmem_wdata_out = wdata_q;
    assign dmem_wstrb_out = wstrb_q;
    assign wb_rd_out      = rd_q;
    assign wb_data_out    = wb_data_q;
    assign fault_addr_out = fault_addr_q;

endmodule

// File: tb/tb_msrv32_lsu.sv
module tb_msrv32_lsu;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in = 1'b0, load_in = 1'b0, store_in = 1'b0;
    logic [2:0]  funct3_in = '0;
    logic [31:0] addr_in = '0, store_data_in = '0;
    logic [4:0]  rd_addr_in = '0;
    logic        ready_out, dmem_req_out, dmem_we_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out;
    logic [3:0]  dmem_wstrb_out;
    logic        dmem_ack_in = 1'b0, dmem_err_in = 1'b0;
    logic [31:0] dmem_rdata_in = '0;
    logic        done_out, wb_we_out, misaligned_out, access_fault_out;
    logic [4:0]  wb_rd_out;
    logic [31:0] wb_data_out, fault_addr_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrv32_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .valid_in         (valid_in),
        .load_in          (load_in),
        .store_in         (store_in),
        .funct3_in        (funct3_in),
        .addr_in          (addr_in),
        .store_data_in    (store_data_in),
        .rd_addr_in       (rd_addr_in),
        .ready_out        (ready_out),
        .dmem_req_out     (dmem_req_out),
        .dmem_we_out      (dmem_we_out),
        .dmem_addr_out    (dmem_addr_out),
        .dmem_wdata_out   (dmem_wdata_out),
        .dmem_wstrb_out   (dmem_wstrb_out),
        .dmem_ack_in      (dmem_ack_in),
        .dmem_err_in      (dmem_err_in),
        .dmem_rdata_in    (dmem_rdata_in),
        .done_out         (done_out),
        .wb_we_out        (wb_we_out),
        .wb_rd_out        (wb_rd_out),
        .wb_data_out      (wb_data_out),
        .misaligned_out   (misaligned_out),
        .access_fault_out (access_fault_out),
        .fault_addr_out   (fault_addr_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one instruction for a single clock edge; returns #1 after that edge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        @(negedge clk);
        valid_in = 1'b1; load_in = ld; store_in = st; funct3_in = f3;
        addr_in = a; store_data_in = d; rd_addr_in = rd;
        @(posedge clk); #1;
        valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
    endtask

    // Holds off ack for `waits` cycles checking bus stability, then acks; returns in DONE.
    task automatic respond(input int waits, input logic [31:0] rdata, input logic err);
        logic [31:0] a0;
        a0 = dmem_addr_out;
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", dmem_req_out, 1);
            chk("wait_addr", dmem_addr_out, a0);
            chk("wait_ready", ready_out, 0);
            chk("wait_done", done_out, 0);
            @(posedge clk); #1;
        end
        dmem_ack_in = 1'b1; dmem_rdata_in = rdata; dmem_err_in = err;
        @(posedge clk); #1;
        dmem_ack_in = 1'b0; dmem_err_in = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, a, 32'h0, 5'd7);
        chk({tag, "_req"}, dmem_req_out, 1);
        chk({tag, "_we"}, dmem_we_out, 0);
        chk({tag, "_wstrb"}, dmem_wstrb_out, 4'b0000);
        chk({tag, "_addr"}, dmem_addr_out, {a[31:2], 2'b00});
        respond(0, rdata, 1'b0);
        chk({tag, "_done"}, done_out, 1);
        chk({tag, "_wbwe"}, wb_we_out, 1);
        chk({tag, "_wbrd"}, wb_rd_out, 5'd7);
        chk({tag, "_data"}, wb_data_out, exp);
        @(posedge clk); #1;
        chk({tag, "_hold"}, wb_data_out, exp);
        chk({tag, "_wbwe_off"}, wb_we_out, 0);
    endtask

    task automatic fault_case(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic exp_mis);
        issue(ld, st, f3, a, 32'h1234_5678, 5'd3);
        chk({tag, "_done"}, done_out, 1);
        chk({tag, "_mis"}, misaligned_out, exp_mis);
        chk({tag, "_af"}, access_fault_out, !exp_mis);
        chk({tag, "_wbwe"}, wb_we_out, 0);
        chk({tag, "_faddr"}, fault_addr_out, a);
        chk({tag, "_rd"}, wb_rd_out, 5'd3);
        chk({tag, "_noreq"}, dmem_req_out, 0);
        @(posedge clk); #1;
        chk({tag, "_idle"}, ready_out, 1);
        chk({tag, "_noreq2"}, dmem_req_out, 0);
        chk({tag, "_doneoff"}, done_out, 0);
    endtask

    initial begin
        int n;
        logic seen_done;

        rst_n = 1'b0;
        #12;
        chk("rst_ready", ready_out, 1);
        chk("rst_req", dmem_req_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_wstrb", dmem_wstrb_out, 0);
        chk("rst_wbdata", wb_data_out, 0);
        chk("rst_faddr", fault_addr_out, 0);
        chk("rst_flags", {wb_we_out, misaligned_out, access_fault_out}, 0);
        @(negedge clk); rst_n = 1'b1;

        // SW aligned
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd5);
        chk("sw_req", dmem_req_out, 1);
        chk("sw_we", dmem_we_out, 1);
        chk("sw_addr", dmem_addr_out, 32'h100);
        chk("sw_wdata", dmem_wdata_out, 32'hDEAD_BEEF);
        chk("sw_wstrb", dmem_wstrb_out, 4'b1111);
        chk("sw_ready", ready_out, 0);
        respond(0, 32'h0, 1'b0);
        chk("sw_done", done_out, 1);
        chk("sw_wbwe", wb_we_out, 0);
        chk("sw_flags", {misaligned_out, access_fault_out}, 0);
        chk("sw_rd", wb_rd_out, 5'd5);
        chk("sw_reqoff", dmem_req_out, 0);
        @(posedge clk); #1;
        chk("sw_idle", ready_out, 1);
        chk("sw_doneoff", done_out, 0);

        // SB top lane
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd1);
        chk("sb_wdata", dmem_wdata_out, 32'hA5A5_A5A5);
        chk("sb_wstrb", dmem_wstrb_out, 4'b1000);
        chk("sb_addr", dmem_addr_out, 32'h100);
        respond(0, 32'h0, 1'b0);
        chk("sb_done", done_out, 1);
        @(posedge clk); #1;

        // SH upper half
        issue(1'b0, 1'b1, 3'b001, 32'h206, 32'hFFFF_1234, 5'd1);
        chk("sh_wdata", dmem_wdata_out, 32'h1234_1234);
        chk("sh_wstrb", dmem_wstrb_out, 4'b1100);
        chk("sh_addr", dmem_addr_out, 32'h204);
        respond(0, 32'h0, 1'b0);
        @(posedge clk); #1;

        load_case("lb",  3'b000, 32'h102, 32'h0080_FF00, 32'hFFFF_FF80);
        load_case("lbu", 3'b100, 32'h102, 32'h0080_FF00, 32'h0000_0080);
        load_case("lhu", 3'b101, 32'h102, 32'h0080_FF00, 32'h0000_0080);
        load_case("lh",  3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
        load_case("lw",  3'b010, 32'h104, 32'h1234_5678, 32'h1234_5678);

        fault_case("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 1'b1);
        fault_case("lh_mis", 1'b1, 1'b0, 3'b001, 32'h101, 1'b1);
        fault_case("sw_mis", 1'b0, 1'b1, 3'b010, 32'h201, 1'b1);
        fault_case("ld_ill", 1'b1, 1'b0, 3'b011, 32'h101, 1'b0);
        fault_case("st_ill", 1'b0, 1'b1, 3'b100, 32'h100, 1'b0);
        fault_case("ld_st",  1'b1, 1'b1, 3'b010, 32'h300, 1'b0);

        // no-op issue and stray ack in IDLE
        issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 5'd9);
        chk("nop_ready", ready_out, 1);
        chk("nop_req", dmem_req_out, 0);
        chk("nop_done", done_out, 0);
        dmem_ack_in = 1'b1;
        @(posedge clk); #1;
        dmem_ack_in = 1'b0;
        chk("idleack_done", done_out, 0);
        chk("idleack_ready", ready_out, 1);

        // load with three wait states
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd12);
        respond(3, 32'hCAFE_F00D, 1'b0);
        chk("wait_done1", done_out, 1);
        chk("wait_data", wb_data_out, 32'hCAFE_F00D);
        chk("wait_rd", wb_rd_out, 5'd12);
        @(posedge clk); #1;

        // bus error
        issue(1'b1, 1'b0, 3'b000, 32'h503, 32'h0, 5'd4);
        respond(1, 32'h0000_0011, 1'b1);
        chk("err_done", done_out, 1);
        chk("err_af", access_fault_out, 1);
        chk("err_wbwe", wb_we_out, 0);
        chk("err_faddr", fault_addr_out, 32'h503);
        chk("err_data_held", wb_data_out, 32'hCAFE_F00D);
        @(posedge clk); #1;

        // timeout
        issue(1'b0, 1'b1, 3'b010, 32'h600, 32'h1, 5'd2);
        n = 0;
        while (dmem_req_out && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("to_cycles", n, TO);
        chk("to_done", done_out, 1);
        chk("to_af", access_fault_out, 1);
        chk("to_faddr", fault_addr_out, 32'h600);
        @(posedge clk); #1;
        chk("to_idle", ready_out, 1);

        // reset mid-BUSY
        issue(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 5'd6);
        chk("rb_req", dmem_req_out, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rb_reqoff", dmem_req_out, 0);
        chk("rb_ready", ready_out, 1);
        chk("rb_done", done_out, 0);
        @(negedge clk); rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done_out) seen_done = 1'b1;
        end
        chk("rb_nodone", seen_done, 0);
        chk("rb_idle", ready_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

endmodule
